// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter/sequencer turning port A/B read/write requests into the
// SPI command RAM's two-word command sequence and returning read data.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [7:0]           a_wdata,
  output logic                 a_ack,
  output logic [7:0]           a_rdata,
  output logic                 a_err,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [7:0]           b_wdata,
  output logic                 b_ack,
  output logic [7:0]           b_rdata,
  output logic                 b_err,
  output logic [9:0]           ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]    state_q, state_d;
  logic          last_b_q, last_b_d;   // 1 = B was granted last
  logic          gnt_b_q, gnt_b_d;
  logic          we_q, we_d;
  logic [7:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    ram_din_q, ram_din_d;
  logic          ram_rx_valid_q, ram_rx_valid_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [7:0]    a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          a_err_q, a_err_d, b_err_q, b_err_d;
  logic          busy_q, busy_d;

  logic          gnt, fin, upd, rd_err;
  logic [7:0]    a_ext, b_ext, rd_val;

  always_comb begin
    state_d        = state_q;
    last_b_d       = last_b_q;
    gnt_b_d        = gnt_b_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = 1'b0;
    a_ack_d        = 1'b0;
    b_ack_d        = 1'b0;
    a_rdata_d      = a_rdata_q;
    b_rdata_d      = b_rdata_q;
    a_err_d        = a_err_q;
    b_err_d        = b_err_q;
    gnt            = 1'b0;
    fin            = 1'b0;
    upd            = 1'b0;
    rd_val         = 8'h00;
    rd_err         = 1'b0;
    a_ext          = '0;
    b_ext          = '0;
    a_ext[ADDR_SIZE-1:0] = a_addr;
    b_ext[ADDR_SIZE-1:0] = b_addr;

    // Outputs are registered, so each state computes what the next state shows.
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          gnt            = b_req && (!a_req || !last_b_q);
          gnt_b_d        = gnt;
          last_b_d       = gnt;
          we_d           = gnt ? b_we : a_we;
          addr_d         = gnt ? b_ext : a_ext;
          wdata_d        = gnt ? b_wdata : a_wdata;
          ram_din_d      = {(we_d ? 2'b00 : 2'b10), addr_d};
          ram_rx_valid_d = 1'b1;
          state_d        = S_ADDR;
        end
      end
      S_ADDR: begin
        ram_din_d      = we_q ? {2'b01, wdata_q} : {2'b11, 8'h00};
        ram_rx_valid_d = 1'b1;
        state_d        = S_DATA;
      end
      S_DATA: begin
        cnt_d = '0;
        if (we_q) begin
          fin     = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ram_tx_valid) begin
          fin     = 1'b1;
          upd     = 1'b1;
          rd_val  = ram_dout;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fin     = 1'b1;
          upd     = 1'b1;
          rd_err  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      a_ack_d = !gnt_b_q;
      b_ack_d = gnt_b_q;
      if (upd && gnt_b_q) begin
        b_rdata_d = rd_val;
        b_err_d   = rd_err;
      end else if (upd) begin
        a_rdata_d = rd_val;
        a_err_d   = rd_err;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      last_b_q       <= 1'b1;
      gnt_b_q        <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 8'h00;
      wdata_q        <= 8'h00;
      cnt_q          <= '0;
      ram_din_q      <= 10'h000;
      ram_rx_valid_q <= 1'b0;
      a_ack_q        <= 1'b0;
      b_ack_q        <= 1'b0;
      a_rdata_q      <= 8'h00;
      b_rdata_q      <= 8'h00;
      a_err_q        <= 1'b0;
      b_err_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_b_q       <= last_b_d;
      gnt_b_q        <= gnt_b_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      a_ack_q        <= a_ack_d;
      b_ack_q        <= b_ack_d;
      a_rdata_q      <= a_rdata_d;
      b_rdata_q      <= b_rdata_d;
      a_err_q        <= a_err_d;
      b_err_q        <= b_err_d;
      busy_q         <= busy_d;
    end
  end

  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
  assign a_ack        = a_ack_q;
  assign b_ack        = b_ack_q;
  assign a_rdata      = a_rdata_q;
  assign b_rdata      = b_rdata_q;
  assign a_err        = a_err_q;
  assign b_err        = b_err_q;
  assign busy         = busy_q;

endmodule
